// File: rtl/sccb_init_seq_if.sv
// rtl/sccb_init_seq_if.sv - request/response bus between the init sequencer and the SCCB engine
interface sccb_init_seq_if;
    logic        sccb_start;
    logic [3:0]  sccb_wr;
    logic [31:0] sccb_data;
    logic        sccb_busy;
    logic [7:0]  sccb_read_data;

    modport master (
        output sccb_start, sccb_wr, sccb_data,
        input  sccb_busy, sccb_read_data
    );

    modport slave (
        input  sccb_start, sccb_wr, sccb_data,
        output sccb_busy, sccb_read_data
    );
endinterface

// File: rtl/sccb_init_seq.sv
// rtl/sccb_init_seq.sv - init-table sequencer and CPU arbiter in front of the SCCB engine
module sccb_init_seq #(
    parameter int         ADDR_W     = 8,
    parameter logic [7:0] DEV_ID     = 8'h78,
    parameter logic [3:0] WR_WRITE   = 4'hF,
    parameter int         ACK_WAIT   = 4,
    parameter bit         AUTO_START = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              init_go,
    output logic              init_done,
    output logic              init_err,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [31:0]       tbl_data,
    input  logic              cpu_start,
    input  logic [3:0]        cpu_wr,
    input  logic [31:0]       cpu_data,
    output logic              cpu_busy,
    output logic [7:0]        cpu_read_data,
    sccb_init_seq_if.master   sccb
);
    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, ISSUE, WAIT_ACK, WAIT_DONE, DELAY, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [7:0]        ACK_LAST  = 8'(ACK_WAIT - 1);

    state_t      state;
    logic        auto_pend;
    logic        cpu_active;
    logic        cpu_ret_done;
    logic [3:0]  cpu_wr_q;
    logic [31:0] cpu_data_q;
    logic [23:0] delay_cnt;
    logic [7:0]  ack_cnt;

    logic unused_bits;
    assign unused_bits = ^tbl_data[29:24];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            auto_pend       <= AUTO_START;
            cpu_active      <= 1'b0;
            cpu_ret_done    <= 1'b0;
            cpu_wr_q        <= 4'd0;
            cpu_data_q      <= 32'd0;
            delay_cnt       <= 24'd0;
            ack_cnt         <= 8'd0;
            init_done       <= 1'b0;
            init_err        <= 1'b0;
            tbl_addr        <= '0;
            cpu_busy        <= 1'b0;
            cpu_read_data   <= 8'd0;
            sccb.sccb_start <= 1'b0;
            sccb.sccb_wr    <= 4'd0;
            sccb.sccb_data  <= 32'd0;
        end else begin
            sccb.sccb_start <= 1'b0;

            // One-deep CPU slot; requests arriving while it is occupied are dropped.
            if (cpu_start && !cpu_busy) begin
                cpu_busy   <= 1'b1;
                cpu_wr_q   <= cpu_wr;
                cpu_data_q <= cpu_data;
            end

            case (state)
                IDLE, DONE: begin
                    if (init_go || (state == IDLE && auto_pend)) begin
                        auto_pend <= 1'b0;
                        init_done <= 1'b0;
                        init_err  <= 1'b0;
                        tbl_addr  <= '0;
                        state     <= FETCH;
                    end else if (cpu_busy) begin
                        sccb.sccb_wr    <= cpu_wr_q;
                        sccb.sccb_data  <= cpu_data_q;
                        sccb.sccb_start <= 1'b1;
                        cpu_active      <= 1'b1;
                        cpu_ret_done    <= (state == DONE);
                        state           <= ISSUE;
                    end
                end

                FETCH: state <= DECODE;

                DECODE: begin
                    case (tbl_data[31:30])
                        2'b00: begin
                            sccb.sccb_data  <= {DEV_ID, tbl_data[23:0]};
                            sccb.sccb_wr    <= WR_WRITE;
                            sccb.sccb_start <= 1'b1;
                            state           <= ISSUE;
                        end
                        2'b01: begin
                            if (tbl_data[23:0] != 24'd0) begin
                                delay_cnt <= tbl_data[23:0];
                                state     <= DELAY;
                            end else if (tbl_addr == LAST_ADDR) begin
                                init_done <= 1'b1;
                                state     <= DONE;
                            end else begin
                                tbl_addr <= tbl_addr + 1'b1;
                                state    <= FETCH;
                            end
                        end
                        2'b10: begin
                            if (tbl_addr == LAST_ADDR) begin
                                init_done <= 1'b1;
                                state     <= DONE;
                            end else begin
                                tbl_addr <= tbl_addr + 1'b1;
                                state    <= FETCH;
                            end
                        end
                        default: begin
                            init_done <= 1'b1;
                            state     <= DONE;
                        end
                    endcase
                end

                ISSUE: begin
                    ack_cnt <= 8'd0;
                    state   <= WAIT_ACK;
                end

                WAIT_ACK: begin
                    if (sccb.sccb_busy) begin
                        state <= WAIT_DONE;
                    end else if (ack_cnt == ACK_LAST) begin
                        // Engine never acknowledged: flag it, then unwind whichever path owned it.
                        init_err <= 1'b1;
                        if (cpu_active) begin
                            cpu_read_data <= 8'd0;
                            cpu_busy      <= 1'b0;
                            cpu_active    <= 1'b0;
                            state         <= cpu_ret_done ? DONE : IDLE;
                        end else begin
                            init_done <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        ack_cnt <= ack_cnt + 8'd1;
                    end
                end

                WAIT_DONE: begin
                    if (!sccb.sccb_busy) begin
                        if (cpu_active) begin
                            cpu_read_data <= sccb.sccb_read_data;
                            cpu_busy      <= 1'b0;
                            cpu_active    <= 1'b0;
                            state         <= cpu_ret_done ? DONE : IDLE;
                        end else if (tbl_addr == LAST_ADDR) begin
                            init_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            tbl_addr <= tbl_addr + 1'b1;
                            state    <= FETCH;
                        end
                    end
                end

                DELAY: begin
                    if (delay_cnt != 24'd1) begin
                        delay_cnt <= delay_cnt - 24'd1;
                    end else if (tbl_addr == LAST_ADDR) begin
                        init_done <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tbl_addr <= tbl_addr + 1'b1;
                        state    <= FETCH;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sccb_init_seq.sv
// tb/tb_sccb_init_seq.sv - scoreboard bench for the SCCB init sequencer
module tb_sccb_init_seq;
    localparam int ENG_BUSY = 5;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        init_go = 1'b0;
    logic        init_done, init_err;
    logic [7:0]  tbl_addr;
    logic [31:0] tbl_data;
    logic        cpu_start = 1'b0;
    logic [3:0]  cpu_wr = 4'd0;
    logic [31:0] cpu_data = 32'd0;
    logic        cpu_busy;
    logic [7:0]  cpu_read_data;

    sccb_init_seq_if sif();

    sccb_init_seq dut (
        .clk(clk), .rstn(rstn), .init_go(init_go), .init_done(init_done),
        .init_err(init_err), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .cpu_start(cpu_start), .cpu_wr(cpu_wr), .cpu_data(cpu_data),
        .cpu_busy(cpu_busy), .cpu_read_data(cpu_read_data), .sccb(sif)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [256];
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    // Engine model: busy for ENG_BUSY cycles after each accepted start, unless dead.
    logic       eng_dead = 1'b0;
    int         eng_cnt = 0;
    always @(posedge clk) begin
        if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
        else if (sif.sccb_start && !eng_dead) eng_cnt <= ENG_BUSY;
    end
    assign sif.sccb_busy      = (eng_cnt != 0);
    assign sif.sccb_read_data = 8'h56;

    int pass_cnt = 0;
    int total_cnt = 0;
    int start_cnt = 0;
    logic [35:0] sb_q [$];
    logic [7:0]  rd_q [$];

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every start pulse pops the next expected {wr,data}.
    always @(negedge clk) begin
        if (sif.sccb_start) begin
            start_cnt++;
            if (sb_q.size() == 0) chk("unexpected_start", {sif.sccb_wr, sif.sccb_data}, 36'h0);
            else chk("sccb_txn", {sif.sccb_wr, sif.sccb_data}, sb_q.pop_front());
        end
    end

    // Monitor: each cpu_busy fall pops the expected read byte.
    logic cpu_busy_prev = 1'b0;
    always @(negedge clk) begin
        if (cpu_busy_prev && !cpu_busy) begin
            if (rd_q.size() == 0) chk("unexpected_cpu_done", {28'd0, cpu_read_data}, 36'h0);
            else chk("cpu_read_data", {28'd0, cpu_read_data}, {28'd0, rd_q.pop_front()});
        end
        cpu_busy_prev = cpu_busy;
    end

    task automatic fill_rom(input logic [31:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    task automatic pulse_go();
        @(posedge clk); #1 init_go = 1'b1;
        @(posedge clk); #1 init_go = 1'b0;
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (!init_done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, {35'd0, init_done}, 36'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start"}, {35'd0, sif.sccb_start}, 36'd0);
        chk({tag, "_wr"}, {32'd0, sif.sccb_wr}, 36'd0);
        chk({tag, "_data"}, {4'd0, sif.sccb_data}, 36'd0);
        chk({tag, "_addr"}, {28'd0, tbl_addr}, 36'd0);
        chk({tag, "_done_err_busy"}, {33'd0, init_done, init_err, cpu_busy}, 36'd0);
        chk({tag, "_cpu_rd"}, {28'd0, cpu_read_data}, 36'd0);
    endtask

    int n;

    initial begin
        // Auto-start with one write then end.
        fill_rom(32'hC000_0000);
        rom[0] = 32'h0012_3456;
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("reset");
        sb_q.push_back({4'hF, 32'h7812_3456});
        @(negedge clk) rstn = 1'b1;
        wait_done("auto_done", n);
        chk("auto_latency", n, 12);
        chk("auto_addr", {28'd0, tbl_addr}, 36'd1);
        chk("auto_err", {35'd0, init_err}, 36'd0);
        chk("auto_starts", start_cnt, 1);

        // Delay of 16 then zero delay then end.
        fill_rom(32'hC000_0000);
        rom[0] = 32'h4000_0010;
        rom[1] = 32'h4000_0000;
        start_cnt = 0;
        pulse_go();
        wait_done("delay_done", n);
        chk("delay16_latency", n, 22);
        rom[0] = 32'h4000_0000;
        rom[1] = 32'hC000_0000;
        pulse_go();
        wait_done("delay0_done", n);
        chk("delay0_latency", n, 4);
        chk("delay_starts", start_cnt, 0);

        // Dead engine: ack timeout on entry 1, then restart from 0.
        fill_rom(32'hC000_0000);
        rom[0] = 32'h8000_0000;
        rom[1] = 32'h0012_3456;
        eng_dead = 1'b1;
        sb_q.push_back({4'hF, 32'h7812_3456});
        pulse_go();
        wait_done("tmo_done", n);
        chk("tmo_latency", n, 9);
        chk("tmo_err", {35'd0, init_err}, 36'd1);
        chk("tmo_addr", {28'd0, tbl_addr}, 36'd1);
        eng_dead = 1'b0;
        sb_q.push_back({4'hF, 32'h7812_3456});
        pulse_go();
        chk("go_clears", {33'd0, init_done, init_err, 1'b0}, 36'd0);
        chk("go_addr0", {28'd0, tbl_addr}, 36'd0);
        wait_done("retry_done", n);
        chk("retry_addr", {28'd0, tbl_addr}, 36'd2);
        chk("retry_err", {35'd0, init_err}, 36'd0);

        // CPU request deferred behind a running table; second request ignored.
        fill_rom(32'hC000_0000);
        rom[0] = 32'h0012_3456;
        rom[1] = 32'h00AB_CDEF;
        sb_q.push_back({4'hF, 32'h7812_3456});
        sb_q.push_back({4'hF, 32'h78AB_CDEF});
        sb_q.push_back({4'h3, 32'h7930_0A00});
        rd_q.push_back(8'h56);
        pulse_go();
        repeat (2) @(posedge clk);
        #1 cpu_start = 1'b1; cpu_wr = 4'h3; cpu_data = 32'h7930_0A00;
        @(posedge clk); #1 cpu_start = 1'b0;
        chk("cpu_busy_rise", {35'd0, cpu_busy}, 36'd1);
        repeat (2) @(posedge clk);
        #1 cpu_start = 1'b1; cpu_wr = 4'h1; cpu_data = 32'h1111_1111;
        @(posedge clk); #1 cpu_start = 1'b0;
        wait_done("cpu_tbl_done", n);
        chk("cpu_deferred", {35'd0, cpu_busy}, 36'd1);
        chk("cpu_tbl_addr", {28'd0, tbl_addr}, 36'd2);
        n = 0;
        while (cpu_busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cpu_busy_fall", {35'd0, cpu_busy}, 36'd0);
        chk("cpu_done_kept", {35'd0, init_done}, 36'd1);
        repeat (10) @(posedge clk);

        // Full table, no end marker: last entry executes, no wrap.
        fill_rom(32'h8000_0000);
        rom[255] = 32'h00FF_00AA;
        sb_q.push_back({4'hF, 32'h78FF_00AA});
        pulse_go();
        wait_done("full_done", n);
        chk("full_addr", {28'd0, tbl_addr}, 36'd255);
        repeat (20) @(posedge clk);
        #1 chk("full_no_wrap", {28'd0, tbl_addr}, 36'd255);

        // Async reset in WAIT_DONE, then auto restart from 0.
        fill_rom(32'hC000_0000);
        rom[0] = 32'h0012_3456;
        sb_q.push_back({4'hF, 32'h7812_3456});
        sb_q.push_back({4'hF, 32'h7812_3456});
        pulse_go();
        n = 0;
        while (!sif.sccb_busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_engine_busy", {35'd0, sif.sccb_busy}, 36'd1);
        @(posedge clk); #1 rstn = 1'b0;
        #1 chk_reset_vals("midrst");
        repeat (8) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        wait_done("rst_restart_done", n);
        chk("rst_restart_addr", {28'd0, tbl_addr}, 36'd1);
        repeat (5) @(posedge clk);

        chk("sb_empty", sb_q.size(), 0);
        chk("rd_empty", rd_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/sccb_init_seq.md
# sccb_init_seq

Sequencer and arbiter in front of the SCCB engine. It walks a camera init table held in an external synchronous ROM and turns each entry into an SCCB write or a timed delay. It also shares the engine with CPU transactions that arrive from the APB register block. It sits between the register block, the init ROM and the SCCB engine inside the SCCB/GPIO subsystem.

## Interface
Parameters:
- ADDR_W, 8: init table address width; table depth is 2^ADDR_W entries.
- DEV_ID, 8'h78: SCCB device write ID, placed in sccb_data[31:24] for table writes.
- WR_WRITE, 4'hF: value driven on sccb_wr for table writes.
- ACK_WAIT, 4: maximum cycles to wait for sccb_busy to rise after sccb_start.
- AUTO_START, 1: if 1, the table sequence starts automatically after reset.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- init_go  in  1  pulse; restarts the table from entry 0.
- init_done  out  1  high once the sequence has ended or aborted; cleared by a new start.
- init_err  out  1  sticky error flag (ack timeout); cleared by a new start.
- tbl_addr  out  ADDR_W  ROM address.
- tbl_data  in  32  ROM data, valid one cycle after tbl_addr.
- cpu_start  in  1  pulse; CPU transaction request.
- cpu_wr  in  4  CPU WR code, sampled with cpu_start.
- cpu_data  in  32  CPU DataIn, sampled with cpu_start.
- cpu_busy  out  1  high from cpu_start until the CPU transaction completes.
- cpu_read_data  out  8  sccb_read_data captured at CPU transaction end.
- sccb_start  out  1  one-cycle start pulse to the engine.
- sccb_wr  out  4  WR code to the engine.
- sccb_data  out  32  DataIn to the engine.
- sccb_busy  in  1  engine busy.
- sccb_read_data  in  8  engine read byte.

## Operation
- Entry format (tbl_data[31:30]):
  - 00: write. sccb_data = {DEV_ID, tbl_data[23:8], tbl_data[7:0]}; sccb_wr = WR_WRITE.
  - 01: delay of tbl_data[23:0] cycles.
  - 10: no-op; the sequencer advances.
  - 11: end.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_ACK, WAIT_DONE, DELAY, DONE.
- Table path:
  - FETCH drives tbl_addr, then moves to DECODE.
  - DECODE branches by opcode.
  - ISSUE pulses sccb_start, then moves to WAIT_ACK.
  - WAIT_ACK moves to WAIT_DONE when sccb_busy=1, or aborts after ACK_WAIT cycles.
  - WAIT_DONE waits for sccb_busy=0, then increments the address and returns to FETCH.
  - DELAY counts down to 0, then advances. A count of 0 advances with no DELAY cycles.
- End or abort: the sequencer enters DONE and sets init_done=1.
- The table end has no wrap-around. After the entry at address 2^ADDR_W-1 executes, the sequencer enters DONE.
- CPU path:
  - cpu_start is latched into a one-deep pending slot (data and wr captured) and cpu_busy goes to 1.
  - A further cpu_start while cpu_busy=1 is ignored.
  - A pending request is served only from IDLE or DONE. A running table sequence has strict priority.
  - The CPU transaction uses the same ISSUE/WAIT_ACK/WAIT_DONE states with the captured wr/data.
  - On completion, cpu_read_data is updated, cpu_busy goes to 0, and the FSM returns to the state it came from (IDLE or DONE).
- Ack timeout on either path sets init_err=1.
  - A table-path timeout aborts the table into DONE.
  - A CPU-path timeout completes the CPU request with cpu_read_data=0.
- init_go:
  - Accepted in IDLE or DONE when no CPU transaction is in flight.
  - Clears init_done, init_err and tbl_addr.
  - Ignored while the sequence runs.
  - If init_go and a pending CPU request coincide in IDLE/DONE, init_go wins; the CPU request waits until the sequence reaches DONE.

## Timing
- Reset values: sccb_start 0, sccb_wr 0, sccb_data 0, tbl_addr 0, init_done 0, init_err 0, cpu_busy 0, cpu_read_data 0. The FSM resets to IDLE.
- Auto-start: with AUTO_START=1, the first cycle after reset release enters FETCH.
- Reset asserted mid-operation forces the reset values immediately. The pending CPU request is lost.
- Table read latency: tbl_addr is driven in FETCH and tbl_data is sampled in DECODE (1 cycle).
- sccb_data/sccb_wr are registered in DECODE (or on CPU grant) and held stable until WAIT_DONE exits.
- sccb_start is high for exactly one cycle (ISSUE).
- Write-entry overhead: 4 cycles plus engine busy time.
- Delay entry with N>0 occupies N cycles in DELAY.
- cpu_busy rises the cycle after cpu_start. It falls in the cycle after sccb_busy is seen low in WAIT_DONE; cpu_read_data is valid in that same cycle.

## Test plan
- Auto-start with table {00_1234_56 → 0x00123456, 0xC0000000}: one sccb_start with sccb_data=0x78123456 and sccb_wr=0xF; after the engine model finishes, init_done=1 and tbl_addr=1.
- Delay entry 0x40000010 followed by end: exactly 16 DELAY cycles and no sccb_start; entry 0x40000000 adds zero DELAY cycles.
- Engine model never raises busy: init_err=1 and init_done=1 after ACK_WAIT=4 cycles; a following init_go clears both and restarts at address 0.
- cpu_start with data 0x79300A00 and wr 0x3 during the sequence: cpu_busy=1 and the transaction is deferred until DONE; it is then issued with that data/wr; cpu_read_data equals the model's 0x56; a second cpu_start while busy is ignored.
- Full 256-entry table with no end marker: executes all entries, enters DONE with no wrap, and tbl_addr stays at 255.
- rstn pulsed low during WAIT_DONE: all outputs return to their reset values asynchronously, and the sequence restarts from 0 after release.
